// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the ICache refill
// path and the DCache refill/store path. DCache has fixed priority; a small
// counter lets ICache through after STARVE_MAX back-to-back DCache wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_valid,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic                ic_ready,
  output logic                ic_rvalid,
  output logic [DATA_W-1:0]   ic_rdata,
  input  logic                dc_valid,
  input  logic                dc_we,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wstrb,
  output logic                dc_ready,
  output logic                dc_rvalid,
  output logic [DATA_W-1:0]   dc_rdata,
  output logic                mem_req,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_len,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_bvalid
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * STRB_W);
  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [7:0]        BURST_LEN  = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RDATA = 3'd2,
    WACK  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;   // 0 = ICache, 1 = DCache
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                ic_ready_d, ic_rvalid_d, dc_ready_d, dc_rvalid_d;
  logic [DATA_W-1:0]   ic_rdata_d, dc_rdata_d;
  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [7:0]          mem_len_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_d;

  logic                dc_wins;

  // DCache wins a tie unless ICache has been passed over STARVE_MAX times
  assign dc_wins = dc_valid && !(ic_valid && (starve_q == STARVE_LIM));

  // Next-state, grant bookkeeping and next values of every registered output
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    starve_d    = starve_q;
    beat_d      = beat_q;
    ic_ready_d  = 1'b0;
    ic_rvalid_d = 1'b0;
    ic_rdata_d  = ic_rdata;
    dc_ready_d  = 1'b0;
    dc_rvalid_d = 1'b0;
    dc_rdata_d  = dc_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_len_d   = mem_len;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;

    case (state_q)
      IDLE: begin
        if (ic_valid || dc_valid) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          beat_d    = '0;
          if (dc_wins) begin
            grant_d = 1'b1;
            if (ic_valid) begin
              starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
            end else begin
              starve_d = '0;
            end
            if (dc_we) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = dc_addr;
              mem_len_d   = 8'd0;
              mem_wdata_d = dc_wdata;
              mem_wstrb_d = dc_wstrb;
            end else begin
              mem_we_d    = 1'b0;
              mem_addr_d  = dc_addr & LINE_MASK;
              mem_len_d   = BURST_LEN;
              mem_wdata_d = '0;
              mem_wstrb_d = '0;
            end
          end else begin
            grant_d     = 1'b0;
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = ic_addr & LINE_MASK;
            mem_len_d   = BURST_LEN;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          mem_req_d = 1'b0;
          state_d   = mem_we ? WACK : RDATA;
        end
      end

      RDATA: begin
        if (mem_rvalid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (grant_q) begin
            dc_rvalid_d = 1'b1;
            dc_rdata_d  = mem_rdata;
          end else begin
            ic_rvalid_d = 1'b1;
            ic_rdata_d  = mem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            state_d    = DONE;
            ic_ready_d = !grant_q;
            dc_ready_d = grant_q;
          end
        end
      end

      WACK: begin
        if (mem_bvalid) begin
          state_d    = DONE;
          ic_ready_d = !grant_q;
          dc_ready_d = grant_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      starve_q  <= '0;
      beat_q    <= '0;
      ic_ready  <= 1'b0;
      ic_rvalid <= 1'b0;
      ic_rdata  <= '0;
      dc_ready  <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_len   <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      starve_q  <= starve_d;
      beat_q    <= beat_d;
      ic_ready  <= ic_ready_d;
      ic_rvalid <= ic_rvalid_d;
      ic_rdata  <= ic_rdata_d;
      dc_ready  <= dc_ready_d;
      dc_rvalid <= dc_rvalid_d;
      dc_rdata  <= dc_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_len   <= mem_len_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
    end
  end

endmodule
